// File: rtl/command_sequencer.sv
// command_sequencer: runs a preloaded buffer of RV32I commands through a run/done handshake with a done timeout.
// Optional build macro SEQ_NOP_SKIP_EN: slots holding the canonical NOP are skipped instead of issued.
module command_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    input  logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     start,
    output logic [31:0]              command,
    output logic                     run,
    input  logic                     done,
    output logic                     busy,
    output logic                     finished,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic [$clog2(DEPTH):0]   retired
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] DEPTH_LEN = LW'(DEPTH);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SKIP,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [LW-1:0] len_reg, len_next;
    logic [LW-1:0] retired_reg, retired_next;
    logic [CW-1:0] wait_reg, wait_next;
    logic [31:0]   cmd_reg, cmd_next;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] pc_inc;
    logic [LW-1:0] len_start;
    logic          last_slot;
    logic          can_start;
    state_t        first_state;
    state_t        after_state;

    assign pc_inc    = pc_reg + AW'(1);
    assign len_start = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
    assign last_slot = ({1'b0, pc_reg} == (len_reg - LW'(1)));
    assign can_start = (state_reg == S_IDLE) || (state_reg == S_FINISH) || (state_reg == S_ERROR);

`ifdef SEQ_NOP_SKIP_EN
    localparam logic [31:0] NOP = 32'h0000_0013;
    assign first_state = (mem[0] == NOP) ? S_SKIP : S_ISSUE;
    assign after_state = (mem[pc_inc] == NOP) ? S_SKIP : S_ISSUE;
`else
    assign first_state = S_ISSUE;
    assign after_state = S_ISSUE;
`endif

    // Writes are only accepted while no program is in flight, so a running program is never corrupted.
    always_ff @(posedge clk) begin
        if (load_en && can_start) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            pc_reg      <= '0;
            len_reg     <= '0;
            retired_reg <= '0;
            wait_reg    <= '0;
            cmd_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            len_reg     <= len_next;
            retired_reg <= retired_next;
            wait_reg    <= wait_next;
            cmd_reg     <= cmd_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        len_next     = len_reg;
        retired_next = retired_reg;
        wait_next    = wait_reg;
        cmd_next     = cmd_reg;
        case (state_reg)
            S_IDLE, S_FINISH, S_ERROR: begin
                if (start) begin
                    len_next     = len_start;
                    pc_next      = '0;
                    retired_next = '0;
                    wait_next    = '0;
                    state_next   = (len_start == '0) ? S_FINISH : first_state;
                end
            end
            S_ISSUE: begin
                cmd_next   = mem[pc_reg];
                wait_next  = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // done is checked first so it wins over a coincident timeout
                if (done) begin
                    retired_next = retired_reg + LW'(1);
                    if (last_slot) begin
                        state_next = S_FINISH;
                    end else begin
                        pc_next    = pc_inc;
                        state_next = after_state;
                    end
                end else begin
                    wait_next = wait_reg + CW'(1);
                    if (wait_reg == WAIT_LAST) begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_SKIP: begin
                if (last_slot) begin
                    state_next = S_FINISH;
                end else begin
                    pc_next    = pc_inc;
                    state_next = after_state;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // During ISSUE the slot is read directly so a write accepted with start is what goes out.
    assign run         = (state_reg == S_ISSUE);
    assign command     = run ? mem[pc_reg] : cmd_reg;
    assign busy        = (state_reg == S_ISSUE) || (state_reg == S_WAIT) || (state_reg == S_SKIP);
    assign finished    = (state_reg == S_FINISH);
    assign timeout_err = (state_reg == S_ERROR);
    assign pc          = pc_reg;
    assign retired     = retired_reg;
endmodule

// File: doc/command_sequencer.md
Name: command_sequencer

Overview:
- Drives the processor's command/run/done interface from a small preloaded program buffer, replacing hand-timed stimulus.
- Issues each 32-bit RV32I command with a one-cycle run pulse, waits for done, then advances to the next command.
- Sits between the program loader (bench or debug port) and the RISC_V_Processor_V0 command input.
- Flags a stalled processor through a done timeout.

Parameters:
- DEPTH, 16: number of 32-bit command slots in the program buffer.
- TIMEOUT, 64: maximum WAIT cycles allowed without done before the block enters ERROR.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- load_en  in  1  writes load_data to buffer[load_addr]; honoured only in IDLE, FINISH or ERROR.
- load_addr  in  $clog2(DEPTH)  buffer write address.
- load_data  in  32  command word to store.
- prog_len  in  $clog2(DEPTH)+1  number of commands to run; sampled on start; values above DEPTH clamp to DEPTH.
- start  in  1  begins a run from slot 0; honoured only in IDLE, FINISH or ERROR.
- command  out  32  command word to the processor.
- run  out  1  one-cycle issue strobe.
- done  in  1  processor completion for the current command.
- busy  out  1  high in ISSUE or WAIT.
- finished  out  1  level; high in FINISH.
- timeout_err  out  1  level; high in ERROR.
- pc  out  $clog2(DEPTH)  index of the current or last command.
- retired  out  $clog2(DEPTH)+1  count of commands completed in the current run.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; command=0, run=0, busy=0, finished=0, timeout_err=0, pc=0, retired=0, wait counter=0. Buffer contents are not reset and are preserved.
- Reset mid-run aborts immediately. Done pulses arriving after the abort are ignored.
- IDLE: on start, latch len=min(prog_len,DEPTH).
  - len==0: go to FINISH next cycle; no run pulse.
  - Otherwise: pc=0, go to ISSUE.
- ISSUE (exactly one cycle): run=1, command=buffer[pc], go to WAIT. done is ignored in this cycle.
- WAIT: run=0; command holds buffer[pc], stable until the next ISSUE.
  - Wait counter increments each cycle done is low.
  - done==1: retired++.
    - If pc==len-1: go to FINISH.
    - Otherwise: pc++, go to ISSUE. The next run pulse comes exactly one cycle after the done cycle.
  - Counter reaches TIMEOUT with no done: go to ERROR; pc and retired hold.
  - done and the timeout condition in the same cycle: done wins.
- FINISH: finished=1; command holds the last value.
- ERROR: timeout_err=1.
- Restart from FINISH or ERROR on start: clear flags, retired=0, pc=0, re-latch len, then ISSUE (or FINISH if len==0).
- Issue latency: start at edge t gives run=1 in cycle t+1.
- Busy collisions: start or load_en while busy are ignored, with no buffer corruption.
- load_en and start in the same cycle: the write happens and start uses the old slot contents for that cycle's decision. Slot 0 is read in ISSUE, so the new data is issued.
- Wait counter width is $clog2(TIMEOUT+1). It clears on every ISSUE.

Optional Feature:
- Macro: SEQ_NOP_SKIP_EN.
- Defined: in IDLE and after each done, slots holding the canonical NOP 32'h00000013 (ADDI x0,x0,0) are skipped.
  - Skipping costs one cycle per skipped slot, with no run pulse and no retired increment.
  - If the last slot is a NOP, go to FINISH after skipping.
- Undefined: NOPs are issued like any other command.

Test Plan:
- Load 3 commands (ADDI x1,x0,10; ADDI x2,x0,-4; ADD x3,x1,x2), prog_len=3, start; model returns done 2 cycles after run -> three run pulses with the correct command each; finished=1, retired=3, x3==6 in the model.
- prog_len=0, start -> finished=1 the next cycle, no run pulse, retired=0.
- prog_len=20 with DEPTH=16, done always 1 cycle after run -> exactly 16 run pulses, consecutive pulses 2 cycles apart.
- Model never asserts done on command 2, TIMEOUT=64 -> timeout_err=1 after 64 WAIT cycles, pc=1, retired=1; start then reruns cleanly from slot 0.
- Drive reset=0 in WAIT of command 1, then release; assert done later -> all outputs at reset values, done ignored, buffer intact on the next run.
- With SEQ_NOP_SKIP_EN: program {ADDI, NOP, NOP, ADD}, len=4 -> 2 run pulses, retired=2, finished=1.
